pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for a five-stage pipeline: stage enables, bubble loads and PC redirect.
// Defining PIPE_CTRL_PERF_EN adds saturating stall/flush performance counters.
module pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             branch_taken_exe,
    input  logic             dmem_req_acc,
    input  logic             dmem_ack,
    output logic             en_fe,
    output logic             en_de,
    output logic             en_exe,
    output logic             en_acc,
    output logic             en_wb,
    output logic             flush_de,
    output logic             flush_exe,
    output logic             pc_sel,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_FLUSH    = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;

    logic hazard_window;
    logic mem_stall;
    logic take_branch;
    logic take_load_use;

    assign state = state_q;

    // Event decode with priority dmem stall > branch > load-use. Hazard inputs are
    // only honoured in RUN and on the releasing cycle of MEM_WAIT; in LU_STALL and
    // FLUSH the exe stage already holds a bubble, so re-acting would double-count.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        hazard_window = 1'b0;
        mem_stall     = 1'b0;
        take_branch   = 1'b0;
        take_load_use = 1'b0;

        hazard_window = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

        if (state_q == ST_MEM_WAIT) begin
            mem_stall = !dmem_ack;
        end else begin
            mem_stall = dmem_req_acc && !dmem_ack;
        end

        take_branch   = hazard_window && !mem_stall && branch_taken_exe;
        take_load_use = hazard_window && !mem_stall && !branch_taken_exe && load_use;
    end

    always_comb begin
        en_fe     = 1'b1;
        en_de     = 1'b1;
        en_exe    = 1'b1;
        en_acc    = 1'b1;
        en_wb     = 1'b1;
        flush_de  = 1'b0;
        flush_exe = 1'b0;
        pc_sel    = 1'b0;

        if (rst) begin
            // Freeze everything and load bubbles so no stale instruction survives reset.
            en_fe     = 1'b0;
            en_de     = 1'b0;
            en_exe    = 1'b0;
            en_acc    = 1'b0;
            en_wb     = 1'b0;
            flush_de  = 1'b1;
            flush_exe = 1'b1;
        end else if (mem_stall) begin
            en_fe  = 1'b0;
            en_de  = 1'b0;
            en_exe = 1'b0;
            en_acc = 1'b0;
            en_wb  = 1'b0;
        end else if (take_branch) begin
            flush_de  = 1'b1;
            flush_exe = 1'b1;
            pc_sel    = 1'b1;
        end else if (take_load_use) begin
            en_fe     = 1'b0;
            en_de     = 1'b0;
            flush_exe = 1'b1;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (mem_stall) begin
            state_d = ST_MEM_WAIT;
        end else if (take_branch) begin
            state_d = ST_FLUSH;
        end else if (take_load_use) begin
            state_d = ST_LU_STALL;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state is updated with non-blocking assignments to avoid ordering races.
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!en_fe && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (pc_sel && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenario tables plus a randomized run against a
// rule-based reference model. Counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Control vector order: {en_fe, en_de, en_exe, en_acc, en_wb, flush_de, flush_exe, pc_sel}
    localparam logic [7:0] C_RUN   = 8'b11111000;
    localparam logic [7:0] C_STALL = 8'b00000000;
    localparam logic [7:0] C_RST   = 8'b00000110;
    localparam logic [7:0] C_BR    = 8'b11111111;
    localparam logic [7:0] C_LU    = 8'b00111010;

    localparam int M_RUN = 0;
    localparam int M_LU  = 1;
    localparam int M_MW  = 2;
    localparam int M_FL  = 3;

    // Input vector order: {rst, load_use, branch_taken_exe, dmem_req_acc, dmem_ack}
    typedef struct packed {
        logic [4:0] in;
        logic [7:0] ctrl;
        logic [1:0] st;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_use = 1'b0;
    logic branch_taken_exe = 1'b0;
    logic dmem_req_acc = 1'b0;
    logic dmem_ack = 1'b0;
    logic en_fe, en_de, en_exe, en_acc, en_wb;
    logic flush_de, flush_exe, pc_sel;
    logic [1:0] state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [7:0] ctrl;

    int total = 0;
    int bad = 0;

    int m_state = M_RUN;
    int m_stall_n = 0;
    int m_flush_n = 0;
    int exp_next = M_RUN;
    logic [7:0] exp_ctrl = C_RST;
    logic cur_r = 1'b1;

    assign ctrl = {en_fe, en_de, en_exe, en_acc, en_wb, flush_de, flush_exe, pc_sel};

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .load_use         (load_use),
        .branch_taken_exe (branch_taken_exe),
        .dmem_req_acc     (dmem_req_acc),
        .dmem_ack         (dmem_ack),
        .en_fe            (en_fe),
        .en_de            (en_de),
        .en_exe           (en_exe),
        .en_acc           (en_acc),
        .en_wb            (en_wb),
        .flush_de         (flush_de),
        .flush_exe        (flush_exe),
        .pc_sel           (pc_sel),
        .state            (state),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference behaviour for one cycle, stated as the controller's rules.
    task automatic predict(input logic [4:0] v);
        logic waiting;
        logic hazards_live;
        cur_r = v[4];
        if (v[4]) begin
            exp_ctrl = C_RST;
            exp_next = M_RUN;
        end else begin
            waiting      = (m_state == M_MW) ? !v[0] : (v[1] && !v[0]);
            hazards_live = (m_state == M_RUN) || (m_state == M_MW);
            if (waiting) begin
                exp_ctrl = C_STALL;
                exp_next = M_MW;
            end else if (hazards_live && v[2]) begin
                exp_ctrl = C_BR;
                exp_next = M_FL;
            end else if (hazards_live && v[3]) begin
                exp_ctrl = C_LU;
                exp_next = M_LU;
            end else begin
                exp_ctrl = C_RUN;
                exp_next = M_RUN;
            end
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_exp(input int n);
        logic [CNT_W-1:0] r;
        r = PERF ? CNT_W'((n > CNT_MAX) ? CNT_MAX : n) : '0;
        return r;
    endfunction

    function automatic row_t mk(input logic [4:0] in, input logic [7:0] c, input logic [1:0] s);
        row_t x;
        x.in   = in;
        x.ctrl = c;
        x.st   = s;
        return x;
    endfunction

    task automatic apply(input logic [4:0] v);
        @(negedge clk);
        rst              = v[4];
        load_use         = v[3];
        branch_taken_exe = v[2];
        dmem_req_acc     = v[1];
        dmem_ack         = v[0];
        #1;
        predict(v);
    endtask

    task automatic advance();
        @(posedge clk);
        if (cur_r) begin
            m_stall_n = 0;
            m_flush_n = 0;
        end else begin
            if (!exp_ctrl[7]) m_stall_n++;
            if (exp_ctrl[0]) m_flush_n++;
        end
        m_state = exp_next;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply({1'b1, 4'($urandom_range(15))});
            total++;
            if (ctrl !== C_RST) begin
                bad++;
                $display("FAIL reset_ctrl[%0d] got=%b exp=%b", i, ctrl, C_RST);
            end
            total++;
            if (state !== 2'd0) begin
                bad++;
                $display("FAIL reset_state[%0d] got=%0d exp=0", i, state);
            end
            total++;
            if (stall_cnt !== '0 || flush_cnt !== '0) begin
                bad++;
                $display("FAIL reset_cnt[%0d] got=%0d/%0d exp=0/0", i, stall_cnt, flush_cnt);
            end
            advance();
        end
        apply(5'b00000);
        total++;
        if (ctrl !== C_RUN || state !== 2'd0) begin
            bad++;
            $display("FAIL reset_release got=%b/%0d exp=%b/0", ctrl, state, C_RUN);
        end
        advance();
    endtask

    task automatic test_load_use();
        row_t rows[$];
        rows.push_back(mk(5'b01000, C_LU,  2'd0));
        rows.push_back(mk(5'b00000, C_RUN, 2'd1));
        rows.push_back(mk(5'b00000, C_RUN, 2'd0));
        rows.push_back(mk(5'b01000, C_LU,  2'd0));
        rows.push_back(mk(5'b01100, C_RUN, 2'd1));
        rows.push_back(mk(5'b00000, C_RUN, 2'd0));
        foreach (rows[i]) begin
            apply(rows[i].in);
            total++;
            if (ctrl !== rows[i].ctrl) begin
                bad++;
                $display("FAIL load_use_ctrl[%0d] got=%b exp=%b", i, ctrl, rows[i].ctrl);
            end
            total++;
            if (state !== rows[i].st) begin
                bad++;
                $display("FAIL load_use_state[%0d] got=%0d exp=%0d", i, state, rows[i].st);
            end
            advance();
        end
    endtask

    task automatic test_mem_wait();
        row_t rows[$];
        rows.push_back(mk(5'b00010, C_STALL, 2'd0));
        rows.push_back(mk(5'b00010, C_STALL, 2'd2));
        rows.push_back(mk(5'b00010, C_STALL, 2'd2));
        rows.push_back(mk(5'b00011, C_RUN,   2'd2));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        rows.push_back(mk(5'b00011, C_RUN,   2'd0));
        rows.push_back(mk(5'b01011, C_LU,    2'd0));
        rows.push_back(mk(5'b00000, C_RUN,   2'd1));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        rows.push_back(mk(5'b00010, C_STALL, 2'd0));
        rows.push_back(mk(5'b01001, C_LU,    2'd2));
        rows.push_back(mk(5'b00000, C_RUN,   2'd1));
        rows.push_back(mk(5'b00010, C_STALL, 2'd0));
        rows.push_back(mk(5'b00000, C_STALL, 2'd2));
        rows.push_back(mk(5'b00001, C_RUN,   2'd2));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        foreach (rows[i]) begin
            apply(rows[i].in);
            total++;
            if (ctrl !== rows[i].ctrl) begin
                bad++;
                $display("FAIL mem_wait_ctrl[%0d] got=%b exp=%b", i, ctrl, rows[i].ctrl);
            end
            total++;
            if (state !== rows[i].st) begin
                bad++;
                $display("FAIL mem_wait_state[%0d] got=%0d exp=%0d", i, state, rows[i].st);
            end
            advance();
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        rows.push_back(mk(5'b01100, C_BR,    2'd0));
        rows.push_back(mk(5'b01000, C_RUN,   2'd3));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        rows.push_back(mk(5'b00100, C_BR,    2'd0));
        rows.push_back(mk(5'b00010, C_STALL, 2'd3));
        rows.push_back(mk(5'b00011, C_RUN,   2'd2));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        rows.push_back(mk(5'b00111, C_BR,    2'd0));
        rows.push_back(mk(5'b00100, C_RUN,   2'd3));
        rows.push_back(mk(5'b00110, C_STALL, 2'd0));
        rows.push_back(mk(5'b00101, C_BR,    2'd2));
        rows.push_back(mk(5'b00000, C_RUN,   2'd3));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        foreach (rows[i]) begin
            apply(rows[i].in);
            total++;
            if (ctrl !== rows[i].ctrl) begin
                bad++;
                $display("FAIL branch_ctrl[%0d] got=%b exp=%b", i, ctrl, rows[i].ctrl);
            end
            total++;
            if (state !== rows[i].st) begin
                bad++;
                $display("FAIL branch_state[%0d] got=%0d exp=%0d", i, state, rows[i].st);
            end
            advance();
        end
    endtask

    task automatic test_branch_in_wait();
        row_t rows[$];
        rows.push_back(mk(5'b00010, C_STALL, 2'd0));
        rows.push_back(mk(5'b00110, C_STALL, 2'd2));
        rows.push_back(mk(5'b00110, C_STALL, 2'd2));
        rows.push_back(mk(5'b00111, C_BR,    2'd2));
        rows.push_back(mk(5'b00000, C_RUN,   2'd3));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        foreach (rows[i]) begin
            apply(rows[i].in);
            total++;
            if (ctrl !== rows[i].ctrl) begin
                bad++;
                $display("FAIL br_wait_ctrl[%0d] got=%b exp=%b", i, ctrl, rows[i].ctrl);
            end
            total++;
            if (state !== rows[i].st) begin
                bad++;
                $display("FAIL br_wait_state[%0d] got=%0d exp=%0d", i, state, rows[i].st);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_wait();
        row_t rows[$];
        rows.push_back(mk(5'b00010, C_STALL, 2'd0));
        rows.push_back(mk(5'b00010, C_STALL, 2'd2));
        rows.push_back(mk(5'b11110, C_RST,   2'd2));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        rows.push_back(mk(5'b00000, C_RUN,   2'd0));
        foreach (rows[i]) begin
            apply(rows[i].in);
            total++;
            if (ctrl !== rows[i].ctrl) begin
                bad++;
                $display("FAIL rst_wait_ctrl[%0d] got=%b exp=%b", i, ctrl, rows[i].ctrl);
            end
            total++;
            if (state !== rows[i].st) begin
                bad++;
                $display("FAIL rst_wait_state[%0d] got=%0d exp=%0d", i, state, rows[i].st);
            end
            if (i == 3) begin
                total++;
                if (stall_cnt !== '0 || flush_cnt !== '0) begin
                    bad++;
                    $display("FAIL rst_wait_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
                end
            end
            advance();
        end
    endtask

    task automatic test_counters();
        logic [CNT_W-1:0] want_stall;
        logic [CNT_W-1:0] want_flush;
        want_stall = CNT_W'(PERF ? 15 : 0);
        apply(5'b10000);
        advance();
        repeat (20) begin
            apply(5'b00010);
            advance();
        end
        apply(5'b00011);
        total++;
        if (stall_cnt !== want_stall) begin
            bad++;
            $display("FAIL stall_cnt_sat got=%0d exp=%0d", stall_cnt, want_stall);
        end
        total++;
        if (flush_cnt !== '0) begin
            bad++;
            $display("FAIL flush_cnt_idle got=%0d exp=0", flush_cnt);
        end
        advance();
        repeat (3) begin
            apply(5'b00100);
            advance();
            apply(5'b00000);
            advance();
        end
        apply(5'b00000);
        want_flush = CNT_W'(PERF ? 3 : 0);
        total++;
        if (flush_cnt !== want_flush) begin
            bad++;
            $display("FAIL flush_cnt got=%0d exp=%0d", flush_cnt, want_flush);
        end
        total++;
        if (stall_cnt !== want_stall) begin
            bad++;
            $display("FAIL stall_cnt_hold got=%0d exp=%0d", stall_cnt, want_stall);
        end
        advance();
    endtask

    task automatic test_random();
        logic [4:0] v;
        for (int i = 0; i < 800; i++) begin
            v[4] = ($urandom_range(31) == 0);
            v[3] = ($urandom_range(3) == 0);
            v[2] = ($urandom_range(3) == 0);
            v[1] = 1'($urandom_range(1));
            v[0] = 1'($urandom_range(1));
            apply(v);
            total++;
            if (ctrl !== exp_ctrl) begin
                bad++;
                $display("FAIL rand_ctrl[%0d] in=%b got=%b exp=%b", i, v, ctrl, exp_ctrl);
            end
            total++;
            if (state !== 2'(m_state)) begin
                bad++;
                $display("FAIL rand_state[%0d] got=%0d exp=%0d", i, state, m_state);
            end
            total++;
            if (stall_cnt !== cnt_exp(m_stall_n) || flush_cnt !== cnt_exp(m_flush_n)) begin
                bad++;
                $display("FAIL rand_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt,
                         cnt_exp(m_stall_n), cnt_exp(m_flush_n));
            end
            total++;
            if (pc_sel && !(&ctrl[7:3])) begin
                bad++;
                $display("FAIL rand_pc_sel_hold[%0d] pc_sel=%b en=%b exp pc_sel=0", i, pc_sel, ctrl[7:3]);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_branch_in_wait();
        test_reset_mid_wait();
        test_counters();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
